// File: rtl/instr_assembler.sv
// RV32 instruction assembler: encodes addi/srai/lw/sw/beq field bundles into 32-bit
// words and streams them through a small FIFO to an instruction-memory write port.
module instr_assembler #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        op_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  output logic              wr_en_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [15:0]       instr_cnt_o,
  output logic [7:0]        err_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_ADDI = 3'd0;
  localparam logic [2:0] OP_SRAI = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ODD   = 2'd2;
  localparam logic [1:0] ERR_OP    = 2'd3;

  logic [31:0]      enc_word;
  logic [1:0]       enc_code;
  logic             fits_i12;
  logic             fits_sh;
  logic             fits_b13;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [31:0]      slot [FIFO_DEPTH];

  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       instr_cnt_reg;
  logic [7:0]        err_cnt_reg;
  logic              err_reg;
  logic [1:0]        err_code_reg;

  logic accept;
  logic push;
  logic reject;
  logic pop;

  // Sign-extension checks: an immediate fits N signed bits when all bits above N-1 agree.
  assign fits_i12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits_b13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits_sh  = ~(|imm_i[31:5]);

  always_comb begin
    enc_word = '0;
    enc_code = ERR_NONE;
    case (op_i)
      OP_ADDI: begin
        enc_word = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'h13};
        if (!fits_i12) enc_code = ERR_RANGE;
      end
      OP_SRAI: begin
        enc_word = {7'b0100000, imm_i[4:0], rs1_i, 3'b101, rd_i, 7'h13};
        if (!fits_sh) enc_code = ERR_RANGE;
      end
      OP_LW: begin
        enc_word = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'h03};
        if (!fits_i12) enc_code = ERR_RANGE;
      end
      OP_SW: begin
        enc_word = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'h23};
        if (!fits_i12) enc_code = ERR_RANGE;
      end
      OP_BEQ: begin
        enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000, imm_i[4:1], imm_i[11], 7'h63};
        if (imm_i[0])      enc_code = ERR_ODD;
        else if (!fits_b13) enc_code = ERR_RANGE;
      end
      default: enc_code = ERR_OP;
    endcase
  end

  // Ready comes from the registered occupancy only, so a full FIFO never takes a bundle
  // even when a pop happens in the same cycle.
  assign in_ready_o = (count_reg != CNT_W'(FIFO_DEPTH));
  assign wr_en_o    = (count_reg != '0);

  assign accept = in_valid_i & in_ready_o;
  assign push   = accept & (enc_code == ERR_NONE);
  assign reject = accept & (enc_code != ERR_NONE);
  assign pop    = wr_en_o & wr_ready_i;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      logic [31:0] entry_reg;
      always_ff @(posedge clk_i) begin
        if (!rst_i && push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= enc_word;
        end
      end
      assign slot[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      addr_reg      <= BASE_ADDR;
      instr_cnt_reg <= '0;
      err_cnt_reg   <= '0;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_NONE;
    end else begin
      count_reg <= count_next;
      err_reg   <= reject;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
        addr_reg      <= addr_reg + ADDR_W'(4);
        instr_cnt_reg <= instr_cnt_reg + 16'd1;
      end
      if (reject) begin
        err_code_reg <= enc_code;
        if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  // Stale slot contents are masked so the data bus reads zero whenever nothing is pending.
  assign wr_data_o   = wr_en_o ? slot[rd_ptr_reg] : 32'h0;
  assign wr_addr_o   = addr_reg;
  assign instr_cnt_o = instr_cnt_reg;
  assign err_cnt_o   = err_cnt_reg;
  assign err_o       = err_reg;
  assign err_code_o  = err_code_reg;

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: directed scenarios plus random traffic checked each cycle
// against a queue-based reference model; a 4-bit-address instance shadows the main one.
module tb_instr_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  op = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        wr_ready = 1'b0;

  logic        in_ready, wr_en, err;
  logic [31:0] wr_addr, wr_data;
  logic [1:0]  err_code;
  logic [15:0] instr_cnt;
  logic [7:0]  err_cnt;

  logic        in_ready_n, wr_en_n, err_n;
  logic [3:0]  wr_addr_n;
  logic [31:0] wr_data_n;
  logic [1:0]  err_code_n;
  logic [15:0] instr_cnt_n;
  logic [7:0]  err_cnt_n;

  always #5 clk = ~clk;

  instr_assembler #(.ADDR_W(32), .BASE_ADDR(32'h0), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .wr_en_o(wr_en), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .err_o(err), .err_code_o(err_code), .instr_cnt_o(instr_cnt), .err_cnt_o(err_cnt)
  );

  instr_assembler #(.ADDR_W(4), .BASE_ADDR(4'h0), .FIFO_DEPTH(4)) dut_n (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_n),
    .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .wr_en_o(wr_en_n), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr_n), .wr_data_o(wr_data_n),
    .err_o(err_n), .err_code_o(err_code_n), .instr_cnt_o(instr_cnt_n), .err_cnt_o(err_cnt_n)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] m_addr = '0;
  int          m_icnt = 0;
  int          m_ecnt = 0;
  logic        m_err = 1'b0;
  logic [1:0]  m_code = '0;

  // Observed completed writes
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] log_cyc[$];
  logic [31:0] log_addr4[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // Encoding and legality derived from field positions and numeric ranges.
  function automatic void ref_encode(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [31:0] im,
                                     output logic [1:0] code, output logic [31:0] word);
    int s;
    logic [31:0] vd, v1, v2;
    s = int'(im);
    vd = 32'(d); v1 = 32'(s1); v2 = 32'(s2);
    code = 2'd0;
    word = 32'h0;
    case (o)
      3'd0: if (s < -2048 || s > 2047) code = 2'd1;
            else word = ((im & 32'hFFF) << 20) | (v1 << 15) | (vd << 7) | 32'h13;
      3'd1: if (s < 0 || s > 31) code = 2'd1;
            else word = (32'h20 << 25) | (im << 20) | (v1 << 15) | (32'd5 << 12) | (vd << 7) | 32'h13;
      3'd2: if (s < -2048 || s > 2047) code = 2'd1;
            else word = ((im & 32'hFFF) << 20) | (v1 << 15) | (32'd2 << 12) | (vd << 7) | 32'h03;
      3'd3: if (s < -2048 || s > 2047) code = 2'd1;
            else word = (((im >> 5) & 32'h7F) << 25) | (v2 << 20) | (v1 << 15) | (32'd2 << 12)
                        | ((im & 32'h1F) << 7) | 32'h23;
      3'd4: if ((im & 32'h1) != 0) code = 2'd2;
            else if (s < -4096 || s > 4094) code = 2'd1;
            else word = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (v2 << 20)
                        | (v1 << 15) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63;
      default: code = 2'd3;
    endcase
  endfunction

  task automatic step();
    logic [1:0]  code;
    logic [31:0] word;
    logic [31:0] head;
    bit acc, pop;
    head = (mq.size() != 0) ? mq[0] : 32'h0;
    if (check_en) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 4));
      chk("wr_en", 32'(wr_en), 32'(mq.size() != 0));
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, head);
      chk("err", 32'(err), 32'(m_err));
      chk("err_code", 32'(err_code), 32'(m_code));
      chk("instr_cnt", 32'(instr_cnt), 32'(m_icnt[15:0]));
      chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
      chk("n_wr_en", 32'(wr_en_n), 32'(mq.size() != 0));
      chk("n_wr_addr", 32'(wr_addr_n), 32'(m_addr[3:0]));
      chk("n_wr_data", wr_data_n, head);
    end
    if (!rst && wr_en && wr_ready) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(32'(cyc));
      log_addr4.push_back(32'(wr_addr_n));
    end
    ref_encode(op, rd, rs1, rs2, imm, code, word);
    if (rst) begin
      mq.delete();
      m_addr = 32'h0; m_icnt = 0; m_ecnt = 0; m_err = 1'b0; m_code = 2'd0;
    end else begin
      acc = in_valid && (mq.size() < 4);
      pop = (mq.size() != 0) && wr_ready;
      if (pop) begin
        void'(mq.pop_front());
        m_addr = m_addr + 32'd4;
        m_icnt++;
      end
      m_err = acc && (code != 2'd0);
      if (m_err) begin
        m_code = code;
        if (m_ecnt < 255) m_ecnt++;
      end
      if (acc && code == 2'd0) mq.push_back(word);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rst) check_en = 1'b1;
  endtask

  task automatic drive(input bit v, input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im, input bit rdy);
    rst = 1'b0; in_valid = v; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; wr_ready = rdy;
    step();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0, rdy);
  endtask

  task automatic do_reset(input bit rdy);
    rst = 1'b1; in_valid = 1'b0; wr_ready = rdy;
    step();
    rst = 1'b0;
    log_addr.delete(); log_data.delete(); log_cyc.delete(); log_addr4.delete();
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges [13];
    int sel;
    edges = '{32'd0, 32'd31, 32'd32, 32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094,
              32'd4095, 32'd4096, -32'sd4096, -32'sd4098, 32'hFFFF_FFFF};
    sel = $urandom_range(0, 5);
    case (sel)
      0:       return edges[$urandom_range(0, 12)];
      1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       return 32'($urandom_range(0, 31));
      3:       return 32'($urandom_range(0, 4095)) * 32'd2 - 32'd4096;
      4:       return $urandom();
      default: return 32'($urandom_range(0, 63)) - 32'd32;
    endcase
  endfunction

  initial begin
    bit accepted;

    // Power-on reset, then the literal reset state
    step();
    do_reset(1'b0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_addr", wr_addr, 32'h0);
    chk("rst_data", wr_data, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_icnt", 32'(instr_cnt), 32'd0);
    chk("rst_ecnt", 32'(err_cnt), 32'd0);

    // addi x1,x0,5: visible the cycle after accept
    drive(1'b1, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    chk("lat_wr_en", 32'(wr_en), 32'd1);
    chk("lat_data", wr_data, 32'h0050_0093);
    chk("lat_addr", wr_addr, 32'h0);
    idle(2, 1'b1);
    chk("lat_count", 32'(log_addr.size()), 32'd1);

    // Back-to-back lw/sw/srai/beq
    do_reset(1'b1);
    drive(1'b1, 3'd2, 5'd2, 5'd1, 5'd0, -32'sd4, 1'b1);
    drive(1'b1, 3'd3, 5'd0, 5'd0, 5'd5, 32'd33, 1'b1);
    drive(1'b1, 3'd1, 5'd3, 5'd3, 5'd0, 32'd15, 1'b1);
    drive(1'b1, 3'd4, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1);
    idle(3, 1'b1);
    chk("b2b_count", 32'(log_addr.size()), 32'd4);
    chk("b2b_lw", at(log_data, 0), 32'hFFC0_A103);
    chk("b2b_sw", at(log_data, 1), 32'h0250_20A3);
    chk("b2b_srai", at(log_data, 2), 32'h40F1_D193);
    chk("b2b_beq", at(log_data, 3), 32'hFE20_8CE3);
    chk("b2b_addr3", at(log_addr, 3), 32'hC);
    chk("b2b_icnt", 32'(instr_cnt), 32'd4);

    // Backpressure: FIFO fills, then drains in consecutive cycles
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 3'd0, 5'd9, 5'd0, 5'd0, 32'd9, 1'b0);
    accepted = 1'b0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      accepted = (mq.size() < 4);
      drive(1'b1, 3'd0, 5'd9, 5'd0, 5'd0, 32'd9, 1'b1);
    end
    chk("release_accept", 32'(accepted), 32'd1);
    idle(6, 1'b1);
    chk("bp_count", 32'(log_addr.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_addr%0d", i), at(log_addr, i), 32'(4 * i));
    for (int i = 0; i < 3; i++) chk($sformatf("bp_consec%0d", i), at(log_cyc, i + 1), at(log_cyc, i) + 32'd1);

    // Rejections
    do_reset(1'b1);
    drive(1'b1, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
    chk("rej_range_err", 32'(err), 32'd1);
    chk("rej_range_code", 32'(err_code), 32'd1);
    drive(1'b1, 3'd4, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
    chk("rej_odd_code", 32'(err_code), 32'd2);
    drive(1'b1, 3'd5, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1);
    chk("rej_op_code", 32'(err_code), 32'd3);
    idle(1, 1'b1);
    chk("rej_err_low", 32'(err), 32'd0);
    chk("rej_code_held", 32'(err_code), 32'd3);
    chk("rej_ecnt", 32'(err_cnt), 32'd3);
    chk("rej_no_write", 32'(log_addr.size()), 32'd0);
    drive(1'b1, 3'd0, 5'd4, 5'd0, 5'd0, 32'd7, 1'b1);
    idle(2, 1'b1);
    chk("rej_next_addr", at(log_addr, 0), 32'h0);

    // Reset drops buffered words
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd0, 5'd1, 5'd0, 5'd0, 32'(i), 1'b0);
    do_reset(1'b0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 3'd0, 5'd6, 5'd0, 5'd0, 32'd1, 1'b1);
    idle(2, 1'b1);
    chk("mid_rst_count", 32'(log_addr.size()), 32'd1);
    chk("mid_rst_addr", at(log_addr, 0), 32'h0);

    // Narrow address instance wraps
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 3'd0, 5'd1, 5'd1, 5'd0, 32'(i), 1'b1);
    idle(3, 1'b1);
    chk("wrap0", at(log_addr4, 0), 32'h0);
    chk("wrap3", at(log_addr4, 3), 32'hC);
    chk("wrap4", at(log_addr4, 4), 32'h0);
    chk("wrap4_wide", at(log_addr, 4), 32'h10);

    // Error counter saturation
    do_reset(1'b1);
    for (int i = 0; i < 258; i++) drive(1'b1, 3'd7, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    idle(1, 1'b1);
    chk("ecnt_sat", 32'(err_cnt), 32'd255);

    // Random traffic
    do_reset(1'b1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        drive(1'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
              5'($urandom()), 5'($urandom()), 5'($urandom()), rand_imm(),
              1'($urandom_range(0, 2) != 0));
      end
    end
    idle(8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
